// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-port Avalon bus arbiter:
//   arb_state_t            - arbiter FSM state encoding (IDLE, BUSY0, BUSY1)
//   PORT_FETCH / PORT_DATA - requester port indices (0 = instruction fetch,
//                            1 = data access)
//   DEFAULT_TIMEOUT_CYCLES - default wait-cycle count for the timeout flag
//   WAIT_CNT_W             - width of the saturating wait counter
//   busy_state()           - maps a port index to its BUSY state
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int WAIT_CNT_W             = 8;

  function automatic arb_state_t busy_state(input logic port);
    return port ? ST_BUSY1 : ST_BUSY0;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// ---------------------------------------------------------------------------
// bus_wait_timer
// Saturating wait-cycle counter with a sticky timeout flag.
//   clk, reset   - clock and synchronous active-high reset
//   start        - arbiter is entering a BUSY state this cycle (clears count)
//   busy         - arbiter is in a BUSY state this cycle
//   waitrequest  - slave stall
//   wait_count   - current wait-cycle count (saturates at all-ones)
//   bus_timeout  - sticky; set on the edge where the count reaches
//                  TIMEOUT_CYCLES, cleared only by reset
// ---------------------------------------------------------------------------
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  busy,
  input  logic                  waitrequest,
  output logic [WAIT_CNT_W-1:0] wait_count,
  output logic                  bus_timeout
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_next;
  logic                  timeout_reg;
  logic                  timeout_next;
  logic                  count_en;

  // Counting only happens in BUSY with the slave stalling; at saturation
  // the counter simply holds.
  assign count_en = busy && waitrequest && (wait_cnt_reg != CNT_MAX);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    if (start) begin
      wait_cnt_next = '0;
    end else if (count_en) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
      // Flag the exact step onto the threshold; later cycles keep it sticky.
      if (int'(wait_cnt_next) == TIMEOUT_CYCLES) begin
        timeout_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign wait_count  = wait_cnt_reg;
  assign bus_timeout = timeout_reg;

endmodule

// File: rtl/avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter
// Two-requester Avalon-MM arbiter (port 0 = instruction fetch, port 1 = data).
//   clk, reset                      - clock, synchronous active-high reset
//   pN_address/read/write/
//     writedata/byteenable (N=0,1)  - requester command inputs
//   pN_waitrequest, pN_readdata     - requester stall and returned read data
//   address/read/write/writedata/
//     byteenable                    - Avalon master outputs
//   waitrequest, readdata           - Avalon slave response
//   bus_timeout                     - sticky: waitrequest held too long
//   protocol_error                  - sticky: a requester raised read+write
// A request is granted from IDLE (round-robin on ties), served in BUSYn with
// the bus driven combinationally from port n, and every transfer returns to
// IDLE, so the minimum request-to-completion latency is two cycles.
// ---------------------------------------------------------------------------
module avalon_bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_address,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [31:0] p0_writedata,
  input  logic [3:0]  p0_byteenable,
  output logic        p0_waitrequest,
  output logic [31:0] p0_readdata,
  input  logic [31:0] p1_address,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [31:0] p1_writedata,
  input  logic [3:0]  p1_byteenable,
  output logic        p1_waitrequest,
  output logic [31:0] p1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_timeout,
  output logic        protocol_error
);

  // Port signals gathered into arrays so the per-port logic is written once.
  logic [31:0] port_address    [2];
  logic [31:0] port_writedata  [2];
  logic [3:0]  port_byteenable [2];
  logic [1:0]  port_read;
  logic [1:0]  port_write;
  logic [1:0]  port_pending;
  logic [1:0]  port_served;
  logic [1:0]  port_waitreq;

  assign port_address[0]    = p0_address;
  assign port_address[1]    = p1_address;
  assign port_writedata[0]  = p0_writedata;
  assign port_writedata[1]  = p1_writedata;
  assign port_byteenable[0] = p0_byteenable;
  assign port_byteenable[1] = p1_byteenable;
  assign port_read          = {p1_read, p0_read};
  assign port_write         = {p1_write, p0_write};

  arb_state_t state_reg;
  arb_state_t state_next;
  logic       last_grant_reg;
  logic       last_grant_next;
  logic       perr_reg;
  logic       perr_next;
  logic       serve_valid;
  logic       serve_port;
  logic       busy_start;

  assign serve_valid = (state_reg == ST_BUSY0) || (state_reg == ST_BUSY1);
  assign serve_port  = (state_reg == ST_BUSY1) ? PORT_DATA : PORT_FETCH;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_pending[gi] = port_read[gi] | port_write[gi];
    assign port_served[gi]  = serve_valid && (serve_port == 1'(gi));
    // A pending port not on the bus is always stalled; the served port sees
    // the slave's stall; an idle port never stalls (covers abandonment too).
    assign port_waitreq[gi] = port_pending[gi] &
                              (port_served[gi] ? waitrequest : 1'b1);
  end

  assign p0_waitrequest = port_waitreq[0];
  assign p1_waitrequest = port_waitreq[1];
  assign p0_readdata    = readdata;
  assign p1_readdata    = readdata;

  // Arbitration and state transitions.
  always_comb begin
    logic grant_valid;
    logic grant_port;
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_valid     = 1'b0;
    grant_port      = PORT_FETCH;
    case (state_reg)
      ST_IDLE: begin
        if (port_pending[0] && port_pending[1]) begin
          grant_valid = 1'b1;
          grant_port  = ~last_grant_reg;
        end else if (port_pending[0]) begin
          grant_valid = 1'b1;
          grant_port  = PORT_FETCH;
        end else if (port_pending[1]) begin
          grant_valid = 1'b1;
          grant_port  = PORT_DATA;
        end
        // Single grants also update last_grant so alternating pairs keep
        // strict p0/p1 alternation.
        if (grant_valid) begin
          state_next      = busy_state(grant_port);
          last_grant_next = grant_port;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        // Completion (waitrequest low) or abandonment both go back to IDLE.
        if (!port_pending[serve_port] || !waitrequest) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_start = (state_reg == ST_IDLE) && (state_next != ST_IDLE);

  // Bus outputs: zero in IDLE, combinational copy of the served port in BUSY.
  // Write wins over a simultaneous read so the bus never sees both.
  always_comb begin
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    if (serve_valid) begin
      address    = port_address[serve_port];
      write      = port_write[serve_port];
      read       = port_read[serve_port] & ~port_write[serve_port];
      writedata  = port_writedata[serve_port];
      byteenable = port_byteenable[serve_port];
    end
  end

  assign perr_next = perr_reg | (p0_read & p0_write) | (p1_read & p1_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= PORT_DATA;
      perr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      perr_reg       <= perr_next;
    end
  end

  assign protocol_error = perr_reg;

  logic [WAIT_CNT_W-1:0] wait_count;

  bus_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (busy_start),
    .busy        (serve_valid),
    .waitrequest (waitrequest),
    .wait_count  (wait_count),
    .bus_timeout (bus_timeout)
  );

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_bus_arbiter
// Directed, table-driven bench for avalon_bus_arbiter: one table row per
// clock cycle with hand-computed expected outputs, followed by a hand-written
// timeout sequence.
// ---------------------------------------------------------------------------
module tb_avalon_bus_arbiter;

  localparam logic [31:0] A0  = 32'h0000_0040;
  localparam logic [31:0] A1  = 32'h0000_1000;
  localparam logic [31:0] WD0 = 32'hAAAA_0000;
  localparam logic [31:0] WD1 = 32'h1234_5678;
  localparam logic [3:0]  BE0 = 4'h3;
  localparam logic [3:0]  BE1 = 4'hF;
  localparam logic [31:0] RD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] p0_address, p1_address;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;
  logic        bus_timeout, protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.TIMEOUT_CYCLES(255)) dut (
    .clk            (clk),
    .reset          (reset),
    .p0_address     (p0_address),
    .p0_read        (p0_read),
    .p0_write       (p0_write),
    .p0_writedata   (p0_writedata),
    .p0_byteenable  (p0_byteenable),
    .p0_waitrequest (p0_waitrequest),
    .p0_readdata    (p0_readdata),
    .p1_address     (p1_address),
    .p1_read        (p1_read),
    .p1_write       (p1_write),
    .p1_writedata   (p1_writedata),
    .p1_byteenable  (p1_byteenable),
    .p1_waitrequest (p1_waitrequest),
    .p1_readdata    (p1_readdata),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .bus_timeout    (bus_timeout),
    .protocol_error (protocol_error)
  );

  typedef struct {
    logic        rst;
    logic        p0r, p0w, p1r, p1w;
    logic        wr;
    logic        e_read, e_write;
    logic [31:0] e_addr;
    logic        chk_addr;
    logic        e_p0wt, e_p1wt;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic p0r, input logic p0w,
                              input logic p1r, input logic p1w, input logic wr,
                              input logic er, input logic ew, input logic [31:0] ea,
                              input logic ca, input logic e0, input logic e1,
                              input logic ep);
    vec_t v;
    v.rst = rst; v.p0r = p0r; v.p0w = p0w; v.p1r = p1r; v.p1w = p1w; v.wr = wr;
    v.e_read = er; v.e_write = ew; v.e_addr = ea; v.chk_addr = ca;
    v.e_p0wt = e0; v.e_p1wt = e1; v.e_perr = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;

    // rst p0r p0w p1r p1w wr | read write addr chk p0wt p1wt perr
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,32'h0,1, 1,0,0)); // 0  p0 read request, IDLE
    vecs.push_back(mk(0,1,0,0,0,0, 1,0,A0,  1, 0,0,0)); // 1  p0 read completes
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,32'h0,1, 0,0,0)); // 2  reset in IDLE
    vecs.push_back(mk(0,1,0,0,1,0, 0,0,32'h0,1, 1,1,0)); // 3  tie after reset
    vecs.push_back(mk(0,1,0,0,1,0, 1,0,A0,  1, 0,1,0)); // 4  p0 served first
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,32'h0,1, 0,1,0)); // 5  back through IDLE
    vecs.push_back(mk(0,0,0,0,1,0, 0,1,A1,  1, 0,0,0)); // 6  p1 write
    for (int r = 0; r < 2; r++) begin                      // 7-14 two tie pairs
      vecs.push_back(mk(0,1,0,0,1,0, 0,0,32'h0,1, 1,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 1,0,A0,  1, 0,1,0));
      vecs.push_back(mk(0,0,0,0,1,0, 0,0,32'h0,1, 0,1,0));
      vecs.push_back(mk(0,0,0,0,1,0, 0,1,A1,  1, 0,0,0));
    end
    vecs.push_back(mk(0,0,0,0,1,1, 0,0,32'h0,1, 0,1,0)); // 15 p1 write alone
    for (int r = 0; r < 3; r++)                            // 16-18 stalled
      vecs.push_back(mk(0,1,0,0,1,1, 0,1,A1,  1, 1,1,0));
    vecs.push_back(mk(0,1,0,0,1,0, 0,1,A1,  1, 1,0,0)); // 19 p1 completes
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,32'h0,1, 1,0,0)); // 20 IDLE before p0
    vecs.push_back(mk(0,1,0,0,0,0, 1,0,A0,  1, 0,0,0)); // 21 p0 completes
    vecs.push_back(mk(0,0,0,1,0,1, 0,0,32'h0,1, 0,1,0)); // 22 p1 read
    vecs.push_back(mk(0,0,0,1,0,1, 1,0,A1,  1, 0,1,0)); // 23 p1 read stalled
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,32'h0,0, 0,0,0)); // 24 abandon
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,32'h0,1, 0,0,0)); // 25 back in IDLE
    vecs.push_back(mk(0,0,0,1,1,0, 0,0,32'h0,1, 0,1,0)); // 26 p1 read+write
    vecs.push_back(mk(0,0,0,1,1,1, 0,1,A1,  1, 0,1,1)); // 27 write only, perr
    vecs.push_back(mk(1,0,0,1,1,1, 0,1,A1,  1, 0,1,1)); // 28 reset mid-BUSY
    vecs.push_back(mk(0,0,0,1,1,1, 0,0,32'h0,1, 0,1,0)); // 29 forced IDLE
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,32'h0,0, 0,0,1)); // 30 abandon + reset
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,32'h0,1, 0,0,0)); // 31 clean

    p0_address = A0;  p0_writedata = WD0; p0_byteenable = BE0;
    p1_address = A1;  p1_writedata = WD1; p1_byteenable = BE1;
    p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
    waitrequest = 0; readdata = RD;
    reset = 1;
    tick();
    tick();
    reset = 0;

    @(negedge clk);
    check("reset read", 32'(read), 32'h0);
    check("reset write", 32'(write), 32'h0);
    check("reset address", address, 32'h0);
    check("reset bus_timeout", 32'(bus_timeout), 32'h0);
    check("reset protocol_error", 32'(protocol_error), 32'h0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      p0_read = vecs[i].p0r; p0_write = vecs[i].p0w;
      p1_read = vecs[i].p1r; p1_write = vecs[i].p1w;
      waitrequest = vecs[i].wr;
      @(negedge clk);
      $display("row %0d: p0 r/w=%b%b p1 r/w=%b%b wr=%b -> read=%b write=%b addr=0x%08h p0wt=%b p1wt=%b perr=%b",
               i, p0_read, p0_write, p1_read, p1_write, waitrequest,
               read, write, address, p0_waitrequest, p1_waitrequest, protocol_error);
      check($sformatf("row%0d read", i), 32'(read), 32'(vecs[i].e_read));
      check($sformatf("row%0d write", i), 32'(write), 32'(vecs[i].e_write));
      check($sformatf("row%0d p0_waitrequest", i), 32'(p0_waitrequest), 32'(vecs[i].e_p0wt));
      check($sformatf("row%0d p1_waitrequest", i), 32'(p1_waitrequest), 32'(vecs[i].e_p1wt));
      check($sformatf("row%0d protocol_error", i), 32'(protocol_error), 32'(vecs[i].e_perr));
      check($sformatf("row%0d bus_timeout", i), 32'(bus_timeout), 32'h0);
      if (vecs[i].chk_addr) begin
        exp_wd = (vecs[i].e_addr == A0) ? WD0 : (vecs[i].e_addr == A1) ? WD1 : 32'h0;
        exp_be = (vecs[i].e_addr == A0) ? BE0 : (vecs[i].e_addr == A1) ? BE1 : 4'h0;
        check($sformatf("row%0d address", i), address, vecs[i].e_addr);
        check($sformatf("row%0d writedata", i), writedata, exp_wd);
        check($sformatf("row%0d byteenable", i), 32'(byteenable), 32'(exp_be));
      end
      if (vecs[i].e_read && !vecs[i].wr) begin
        check($sformatf("row%0d p0_readdata", i), p0_readdata, RD);
        check($sformatf("row%0d p1_readdata", i), p1_readdata, RD);
      end
      @(posedge clk);
      #1;
    end
    reset = 0;

    // Timeout: p0 read stalled for 300 cycles with TIMEOUT_CYCLES=255.
    p0_read = 1; waitrequest = 1;
    tick();                           // IDLE -> BUSY0, count cleared
    check("tmo entry bus_timeout", 32'(bus_timeout), 32'h0);
    for (int k = 1; k <= 300; k++) begin
      tick();                         // k stalled BUSY edges so far
      if (k == 254) check("tmo busy cycle 255", 32'(bus_timeout), 32'h0);
      if (k == 255) check("tmo busy cycle 256", 32'(bus_timeout), 32'h1);
      if (k == 300) begin
        check("tmo busy cycle 301", 32'(bus_timeout), 32'h1);
        check("tmo read held", 32'(read), 32'h1);
        check("tmo address held", address, A0);
        check("tmo p0_waitrequest", 32'(p0_waitrequest), 32'h1);
      end
    end
    $display("timeout sequence: 300 stall cycles, bus_timeout=%b", bus_timeout);
    waitrequest = 0;
    #1;
    check("tmo completion p0_waitrequest", 32'(p0_waitrequest), 32'h0);
    tick();
    p0_read = 0;
    #1;
    check("tmo sticky after completion", 32'(bus_timeout), 32'h1);
    check("tmo back to IDLE read", 32'(read), 32'h0);
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("tmo cleared by reset", 32'(bus_timeout), 32'h0);
    $display("reset after timeout: bus_timeout=%b", bus_timeout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
